// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrating output multiplexer.
package mux_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED,
        MODE_RR,
        MODE_SEL
    } mode_e;

    localparam int unsigned MAX_CH = 16;

endpackage

// File: rtl/rr_arb_v2.sv
// Grant selection for arb_mux_v2: fixed priority, round-robin or explicit select.
module rr_arb_v2
    import mux_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter mode_e       MODE   = MODE_RR
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         valid,
    input  logic [$clog2(NUM_CH)-1:0] sel,
    input  logic                      advance,
    output logic [NUM_CH-1:0]         grant,
    output logic [$clog2(NUM_CH)-1:0] grant_idx,
    output logic                      grant_vld
);

    localparam int unsigned CW = $clog2(NUM_CH);

    logic [CW-1:0] ptr_q, ptr_d;
    logic          found;
    int unsigned   cand;

    always_comb begin
        found     = 1'b0;
        cand      = 0;
        grant_idx = '0;
        case (MODE)
            MODE_FIXED: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (!found && valid[i]) begin
                        found     = 1'b1;
                        grant_idx = CW'(i);
                    end
                end
            end
            MODE_RR: begin
                // Explicit wrap so non-power-of-two channel counts stay in range.
                for (int unsigned off = 0; off < NUM_CH; off++) begin
                    cand = 32'(ptr_q) + off;
                    if (cand >= NUM_CH) begin
                        cand = cand - NUM_CH;
                    end
                    if (!found && valid[cand[CW-1:0]]) begin
                        found     = 1'b1;
                        grant_idx = cand[CW-1:0];
                    end
                end
            end
            default: begin
                // Out-of-range select values match no channel.
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (sel == CW'(i) && valid[i]) begin
                        found     = 1'b1;
                        grant_idx = CW'(i);
                    end
                end
            end
        endcase
        grant_vld = found;
    end

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            grant[i] = grant_vld && (grant_idx == CW'(i));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_vld) begin
            ptr_d = (grant_idx == CW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/arb_mux_v2.sv
// N-to-1 arbitrating multiplexer with a one-entry registered output stage.
module arb_mux_v2
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_CH = 4,
    parameter mode_e       MODE   = MODE_RR
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0][WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [$clog2(NUM_CH)-1:0]    sel,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(NUM_CH)-1:0]    out_ch,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int unsigned CW = $clog2(NUM_CH);

    logic              accept;
    logic              xfer;
    logic              grant_vld;
    logic [NUM_CH-1:0] grant;
    logic [CW-1:0]     grant_idx;
    logic [WIDTH-1:0]  mux_data;

    logic              valid_q;
    logic [WIDTH-1:0]  data_q;
    logic [CW-1:0]     ch_q;

    // Gating with rst_n keeps in_ready low for the whole reset period.
    assign accept   = rst_n && (!valid_q || out_ready);
    assign in_ready = grant & {NUM_CH{accept}};
    assign xfer     = grant_vld && accept;

    rr_arb_v2 #(
        .NUM_CH (NUM_CH),
        .MODE   (MODE)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (in_valid),
        .sel       (sel),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // AND-OR select: non-granted payloads never reach the output.
    always_comb begin
        mux_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            mux_data = mux_data | ({WIDTH{grant[i]}} & in_data[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
        end else if (xfer) begin
            valid_q <= 1'b1;
            data_q  <= mux_data;
            ch_q    <= grant_idx;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;

endmodule
